// File: rtl/plb_reset_requester_pkg.sv
// Shared encodings for the board reset requester: reset cause codes (also read by the
// boot-status logic) and requester FSM states, plus the cause priority selector.
package plb_reset_requester_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_WD   = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_EXT  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ASSERT   = 2'b01,
    ST_WAIT_ACK = 2'b10,
    ST_HOLDOFF  = 2'b11
  } state_e;

  // Simultaneous sources resolve as external > software > watchdog.
  function automatic cause_e cause_select(input logic ext, input logic sw, input logic wd);
    cause_e c;
    if (ext) begin
      c = CAUSE_EXT;
    end else if (sw) begin
      c = CAUSE_SW;
    end else if (wd) begin
      c = CAUSE_WD;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/reset_debounce_sync.sv
// Pushbutton conditioning: 2-FF synchroniser followed by a stability counter; emits a
// one-cycle pulse on each debounced high->low transition.
module reset_debounce_sync #(
  parameter int DEB_CYC = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async_n,
  output logic o_fall
);

  localparam int DEB_W = $clog2(DEB_CYC) + 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DEB_W-1:0] r_cnt;
  logic             r_fall;

  // Synchronise, then accept a new level only after DEB_CYC consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= {DEB_W{1'b0}};
      r_fall   <= 1'b0;
    end else begin
      r_sync1 <= i_async_n;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_stable) begin
        if (r_cnt == DEB_W'(DEB_CYC - 1)) begin
          r_stable <= r_sync2;
          r_cnt    <= {DEB_W{1'b0}};
          r_fall   <= r_stable & ~r_sync2;
        end else begin
          r_cnt  <= r_cnt + DEB_W'(1);
          r_fall <= 1'b0;
        end
      end else begin
        r_cnt  <= {DEB_W{1'b0}};
        r_fall <= 1'b0;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/plb_reset_requester.sv
// Board reset initiator: watchdog, software and pushbutton sources drive an active-low
// reset request to the reset generator and wait for RSTPLB; the last cause is kept sticky.
module plb_reset_requester
  import plb_reset_requester_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int PULSE_CYC   = 16,
  parameter int ACK_TO      = 1024,
  parameter int HOLDOFF_CYC = 64,
  parameter int DEB_CYC     = 256,
  parameter int WARN_CYC    = 1024
) (
  input  logic             CLKPLB,
  input  logic             async_fpga_rst_n,
  input  logic             RSTPLB,
  input  logic             wd_enable,
  input  logic             wd_kick,
  input  logic [CNT_W-1:0] wd_timeout_val,
  input  logic             sw_rst_req,
  input  logic             ext_rst_req_n,
  input  logic             cause_clr,
  output logic             rst_req_n,
  output logic [1:0]       rst_cause,
  output logic             ack_err,
  output logic [CNT_W-1:0] wd_count,
  output logic             wd_warn
);

  localparam int CYC_MAX_A = (PULSE_CYC > ACK_TO) ? PULSE_CYC : ACK_TO;
  localparam int CYC_MAX   = (CYC_MAX_A > HOLDOFF_CYC) ? CYC_MAX_A : HOLDOFF_CYC;
  localparam int CYC_W     = $clog2(CYC_MAX) + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CYC_W-1:0] r_cyc;
  logic [CYC_W-1:0] w_cyc_nxt;
  logic [CNT_W-1:0] r_wd_count;
  logic [CNT_W-1:0] w_wd_count_nxt;
  logic             r_wd_en_d;
  logic             r_wd_warn;
  logic             r_rst_req_n;
  cause_e           r_cause;
  logic             r_ack_err;
  logic             w_ack_to;
  logic             w_ext_fall;
  logic             w_in_idle;
  logic             w_holdoff_done;
  logic             w_wd_load;
  logic             w_wd_dec;
  logic             w_wd_trig;
  logic             w_any_trig;
  logic             w_latch;

  reset_debounce_sync #(
    .DEB_CYC(DEB_CYC)
  ) u_ext_deb (
    .i_clk    (CLKPLB),
    .i_rst_n  (async_fpga_rst_n),
    .i_async_n(ext_rst_req_n),
    .o_fall   (w_ext_fall)
  );

  assign w_in_idle      = (r_state == ST_IDLE);
  assign w_holdoff_done = (r_state == ST_HOLDOFF) && !RSTPLB &&
                          (r_cyc == CYC_W'(HOLDOFF_CYC - 1));
  // A kick on the count's last cycle loads instead of letting the 1->0 step trigger.
  assign w_wd_load      = (w_in_idle && ((wd_enable && !r_wd_en_d) || wd_kick)) ||
                          (w_holdoff_done && wd_enable);
  assign w_wd_dec       = w_in_idle && wd_enable && (r_wd_count != {CNT_W{1'b0}});
  assign w_wd_trig      = w_wd_dec && (r_wd_count == CNT_W'(1)) && !w_wd_load;
  assign w_any_trig     = w_ext_fall | sw_rst_req | w_wd_trig;
  assign w_latch        = w_in_idle && w_any_trig;

  // Watchdog next count.
  always_comb begin
    w_wd_count_nxt = r_wd_count;
    if (w_wd_load) begin
      w_wd_count_nxt = wd_timeout_val;
    end else if (w_wd_dec) begin
      w_wd_count_nxt = r_wd_count - CNT_W'(1);
    end else begin
      w_wd_count_nxt = r_wd_count;
    end
  end

  // Request FSM next state and phase counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_ack_to    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cyc_nxt = {CYC_W{1'b0}};
        if (w_any_trig) begin
          w_state_nxt = ST_ASSERT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (r_cyc == CYC_W'(PULSE_CYC - 1)) begin
          w_state_nxt = ST_WAIT_ACK;
          w_cyc_nxt   = {CYC_W{1'b0}};
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (RSTPLB) begin
          w_state_nxt = ST_HOLDOFF;
          w_cyc_nxt   = {CYC_W{1'b0}};
        end else if (r_cyc == CYC_W'(ACK_TO - 1)) begin
          w_state_nxt = ST_HOLDOFF;
          w_cyc_nxt   = {CYC_W{1'b0}};
          w_ack_to    = 1'b1;
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      ST_HOLDOFF: begin
        // Holdoff timing restarts whenever the generator still shows reset active.
        if (RSTPLB) begin
          w_cyc_nxt = {CYC_W{1'b0}};
        end else if (w_holdoff_done) begin
          w_state_nxt = ST_IDLE;
          w_cyc_nxt   = {CYC_W{1'b0}};
        end else begin
          w_cyc_nxt = r_cyc + CYC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = {CYC_W{1'b0}};
      end
    endcase
  end

  // State, watchdog and registered outputs.
  always_ff @(posedge CLKPLB or negedge async_fpga_rst_n) begin
    if (!async_fpga_rst_n) begin
      r_state     <= ST_IDLE;
      r_cyc       <= {CYC_W{1'b0}};
      r_wd_count  <= {CNT_W{1'b0}};
      r_wd_en_d   <= 1'b0;
      r_wd_warn   <= 1'b0;
      r_rst_req_n <= 1'b1;
      r_cause     <= CAUSE_NONE;
      r_ack_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_wd_count  <= w_wd_count_nxt;
      r_wd_en_d   <= wd_enable;
      r_wd_warn   <= wd_enable && (w_wd_count_nxt != {CNT_W{1'b0}}) &&
                     (w_wd_count_nxt <= CNT_W'(WARN_CYC));
      r_rst_req_n <= !((w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_WAIT_ACK));
      if (w_latch) begin
        r_cause <= cause_select(w_ext_fall, sw_rst_req, w_wd_trig);
      end else if (cause_clr) begin
        r_cause <= CAUSE_NONE;
      end else begin
        r_cause <= r_cause;
      end
      if (w_ack_to) begin
        r_ack_err <= 1'b1;
      end else if (cause_clr) begin
        r_ack_err <= 1'b0;
      end else begin
        r_ack_err <= r_ack_err;
      end
    end
  end

  assign rst_req_n = r_rst_req_n;
  assign rst_cause = r_cause;
  assign ack_err   = r_ack_err;
  assign wd_count  = r_wd_count;
  assign wd_warn   = r_wd_warn;

endmodule

// File: tb/tb_plb_reset_requester.sv
// Scoreboard bench: stimulus pushes expected requests/snapshots, a negedge monitor checks them.
module tb_plb_reset_requester;

  localparam int CNT_W = 24;

  logic             CLKPLB = 1'b0;
  logic             async_fpga_rst_n;
  logic             RSTPLB;
  logic             wd_enable;
  logic             wd_kick;
  logic [CNT_W-1:0] wd_timeout_val;
  logic             sw_rst_req;
  logic             ext_rst_req_n;
  logic             cause_clr;
  logic             rst_req_n;
  logic [1:0]       rst_cause;
  logic             ack_err;
  logic [CNT_W-1:0] wd_count;
  logic             wd_warn;

  plb_reset_requester dut (
    .CLKPLB          (CLKPLB),
    .async_fpga_rst_n(async_fpga_rst_n),
    .RSTPLB          (RSTPLB),
    .wd_enable       (wd_enable),
    .wd_kick         (wd_kick),
    .wd_timeout_val  (wd_timeout_val),
    .sw_rst_req      (sw_rst_req),
    .ext_rst_req_n   (ext_rst_req_n),
    .cause_clr       (cause_clr),
    .rst_req_n       (rst_req_n),
    .rst_cause       (rst_cause),
    .ack_err         (ack_err),
    .wd_count        (wd_count),
    .wd_warn         (wd_warn)
  );

  always #5 CLKPLB = ~CLKPLB;

  int cyc = 0;
  always @(posedge CLKPLB) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [1:0] cause;
    int         fall_cyc;
    int         len;
    logic       aerr;
  } req_t;

  // mask bits: 0 rst_req_n, 1 rst_cause, 2 ack_err, 3 wd_count, 4 wd_warn
  typedef struct {
    string            name;
    logic [4:0]       mask;
    logic             rq;
    logic [1:0]       cause;
    logic             aerr;
    logic [CNT_W-1:0] cnt;
    logic             warn;
  } snap_t;

  req_t  req_q[$];
  snap_t snap_q[$];
  bit    tb_done = 1'b0;

  task automatic tick();
    @(posedge CLKPLB);
    #1;
  endtask

  task automatic push_snap(input string nm, input logic [4:0] m, input logic rq,
                           input logic [1:0] c, input logic ae,
                           input logic [CNT_W-1:0] cn, input logic w);
    snap_t s;
    s.name = nm; s.mask = m; s.rq = rq; s.cause = c; s.aerr = ae; s.cnt = cn; s.warn = w;
    snap_q.push_back(s);
  endtask

  task automatic push_req(input string nm, input logic [1:0] c, input int fc,
                          input int ln, input logic ae);
    req_t r;
    r.name = nm; r.cause = c; r.fall_cyc = fc; r.len = ln; r.aerr = ae;
    req_q.push_back(r);
  endtask

  // Wait for the request, ack 26 cycles after it appears (low length 27), then holdoff.
  task automatic do_ack();
    int n = 0;
    while (rst_req_n !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) push_snap("wait_req_timeout", 5'b00001, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    wd_enable = 1'b0;
    repeat (26) tick();
    RSTPLB = 1'b1;
    repeat (5) tick();
    RSTPLB = 1'b0;
    repeat (80) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  int    checks   = 0;
  int    failures = 0;
  logic  prev_rq  = 1'b1;
  int    low_len  = 0;
  bit    active   = 1'b0;
  req_t  cur;
  snap_t ms;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLKPLB) begin
    while (snap_q.size() > 0) begin
      ms = snap_q.pop_front();
      if (ms.mask[0]) chk({ms.name, ".rst_req_n"}, 32'(rst_req_n), 32'(ms.rq));
      if (ms.mask[1]) chk({ms.name, ".rst_cause"}, 32'(rst_cause), 32'(ms.cause));
      if (ms.mask[2]) chk({ms.name, ".ack_err"}, 32'(ack_err), 32'(ms.aerr));
      if (ms.mask[3]) chk({ms.name, ".wd_count"}, 32'(wd_count), 32'(ms.cnt));
      if (ms.mask[4]) chk({ms.name, ".wd_warn"}, 32'(wd_warn), 32'(ms.warn));
    end
    if (prev_rq === 1'b1 && rst_req_n === 1'b0) begin
      if (req_q.size() == 0) begin
        chk("unexpected_request", 32'(1), 32'(0));
        active = 1'b0;
      end else begin
        cur = req_q[0];
        chk({cur.name, ".fall_cycle"}, 32'(cyc), 32'(cur.fall_cyc));
        chk({cur.name, ".cause"}, 32'(rst_cause), 32'(cur.cause));
        low_len = 1;
        active  = 1'b1;
      end
    end else if (prev_rq === 1'b0 && rst_req_n === 1'b0) begin
      low_len++;
    end else if (prev_rq === 1'b0 && rst_req_n === 1'b1 && active) begin
      chk({cur.name, ".low_len"}, 32'(low_len), 32'(cur.len));
      chk({cur.name, ".ack_err"}, 32'(ack_err), 32'(cur.aerr));
      void'(req_q.pop_front());
      active = 1'b0;
    end
    prev_rq = rst_req_n;
    if (tb_done) begin
      chk("pending_requests", 32'(req_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int p;
    async_fpga_rst_n = 1'b0;
    RSTPLB           = 1'b0;
    wd_enable        = 1'b0;
    wd_kick          = 1'b0;
    wd_timeout_val   = '0;
    sw_rst_req       = 1'b0;
    ext_rst_req_n    = 1'b1;
    cause_clr        = 1'b0;

    // 1: power-on reset values
    repeat (5) tick();
    push_snap("reset_hold", 5'b11111, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    async_fpga_rst_n = 1'b1;
    tick();
    push_snap("after_release", 5'b11111, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    repeat (100) tick();
    push_snap("idle_100", 5'b11111, 1'b1, 2'b00, 1'b0, '0, 1'b0);

    // 2: watchdog expiry, timeout 200
    e = cyc;
    wd_timeout_val = 24'd200;
    wd_enable      = 1'b1;
    push_req("wd_req", 2'b01, e + 201, 27, 1'b0);
    for (int i = 1; i <= 200; i++) begin
      tick();
      push_snap("wd_countdown", 5'b11000, 1'b1, 2'b00, 1'b0, CNT_W'(201 - i), 1'b1);
    end
    do_ack();
    push_snap("wd_after", 5'b11111, 1'b1, 2'b01, 1'b0, '0, 1'b0);

    // 3: periodic kicks keep the watchdog away from expiry
    wd_timeout_val = 24'd2000;
    wd_enable      = 1'b1;
    for (int i = 1; i <= 10000; i++) begin
      tick();
      wd_kick = (i % 1500 == 0);
      p = i % 1500;
      if (p == 1)   push_snap("kick_load", 5'b11000, 1'b1, 2'b00, 1'b0, 24'd2000, 1'b0);
      if (p == 976) push_snap("warn_1025", 5'b11000, 1'b1, 2'b00, 1'b0, 24'd1025, 1'b0);
      if (p == 977) push_snap("warn_1024", 5'b11000, 1'b1, 2'b00, 1'b0, 24'd1024, 1'b1);
    end
    wd_timeout_val = 24'd5;
    wd_kick        = 1'b1;
    tick();
    wd_kick = 1'b0;
    push_snap("short_load", 5'b11000, 1'b1, 2'b00, 1'b0, 24'd5, 1'b1);
    repeat (4) tick();
    push_snap("count_at_1", 5'b11000, 1'b1, 2'b00, 1'b0, 24'd1, 1'b1);
    wd_kick = 1'b1;
    tick();
    wd_kick = 1'b0;
    push_snap("kick_at_1_wins", 5'b01001, 1'b1, 2'b00, 1'b0, 24'd5, 1'b0);
    wd_enable = 1'b0;
    repeat (2) tick();
    push_snap("disabled_holds", 5'b11001, 1'b1, 2'b00, 1'b0, 24'd5, 1'b0);

    // 4: software pulse coincident with debounced ext fall
    e = cyc;
    ext_rst_req_n = 1'b0;
    push_req("sim_req", 2'b11, e + 259, 27, 1'b0);
    repeat (258) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    do_ack();
    ext_rst_req_n = 1'b1;
    repeat (300) tick();
    push_snap("sim_after", 5'b00111, 1'b1, 2'b11, 1'b0, '0, 1'b0);

    // 5: bounce rejection, single request while held low
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    push_snap("clear_before_ext", 5'b00111, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      ext_rst_req_n = 1'b0;
      repeat (100) tick();
      ext_rst_req_n = 1'b1;
      repeat (100) tick();
    end
    push_snap("bounce_ignored", 5'b00111, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    e = cyc;
    ext_rst_req_n = 1'b0;
    push_req("ext_req", 2'b11, e + 259, 27, 1'b0);
    do_ack();
    repeat (300) tick();
    push_snap("ext_held_no_refire", 5'b00111, 1'b1, 2'b11, 1'b0, '0, 1'b0);
    ext_rst_req_n = 1'b1;
    repeat (300) tick();

    // 6: no acknowledge, then clear; clear racing a new latch
    e = cyc;
    sw_rst_req = 1'b1;
    push_req("noack_req", 2'b10, e + 1, 1040, 1'b1);
    tick();
    sw_rst_req = 1'b0;
    repeat (1140) tick();
    push_snap("noack_after", 5'b00111, 1'b1, 2'b10, 1'b1, '0, 1'b0);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    push_snap("cleared", 5'b00111, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    e = cyc;
    sw_rst_req = 1'b1;
    cause_clr  = 1'b1;
    push_req("clr_vs_latch", 2'b10, e + 1, 27, 1'b0);
    tick();
    sw_rst_req = 1'b0;
    cause_clr  = 1'b0;
    do_ack();
    push_snap("latch_beats_clear", 5'b00111, 1'b1, 2'b10, 1'b0, '0, 1'b0);

    tb_done = 1'b1;
    repeat (5) tick();
  end

endmodule
